ascon_serial_host: RTL and testbench
====================================

Name: ascon_serial_host

Overview:
- Host-side driver for the bit-serial Ascon core interface.
- Takes a parallel command (key, nonce, one AD block, one data block, direction) and serializes it onto the core's serial input lanes.
- Pulses start, waits for the core's ready, then deserializes the output data and tag lanes back into a parallel response.
- Sits between the wishbone/register front-end and the core's pins.

Parameters:
- KEY_W, 128, key and nonce lane length in bits.
- BLK_W, 64, AD and data block length in bits.
- TAG_W, 128, tag length in bits.
- TMO_W, 16, watchdog counter width (used only with the optional feature).

Ports:
- clk  in  1  single clock
- rst  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  high only in IDLE
- cmd_decrypt  in  1  1=decrypt, 0=encrypt
- cmd_key  in  KEY_W  key
- cmd_nonce  in  KEY_W  nonce
- cmd_ad  in  BLK_W  associated data block
- cmd_data  in  BLK_W  plaintext/ciphertext block
- rsp_valid  out  1  response held until accepted
- rsp_ready  in  1  response consumer ready
- rsp_data  out  BLK_W  captured output block
- rsp_tag  out  TAG_W  captured tag
- rsp_timeout  out  1  watchdog expired (constant 0 without the macro)
- key_so, nonce_so, ad_so, data_so  out  1 each  serial lanes to the core
- start_so  out  1  one-cycle start pulse
- decrypt_so  out  1  direction level to the core
- out_data_si, tag_si  in  1 each  serial lanes from the core
- ready_si  in  1  core result ready

Behaviour:
- Reset (rst=0, async): state IDLE.
  - All serial outputs, rsp_valid, rsp_data, rsp_tag and rsp_timeout go to 0.
  - cmd_ready=1 (IDLE).
  - Shift registers and counter are cleared.
  - A reset mid-operation aborts immediately; no partial response is produced.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid&cmd_ready, latch all cmd_* fields, set decrypt_so=cmd_decrypt, clear cnt, go to LOAD.
- LOAD (exactly KEY_W cycles, cnt 0..KEY_W-1):
  - key_so and nonce_so present bit [KEY_W-1-cnt], MSB first.
  - ad_so and data_so present bit [BLK_W-1-cnt] for cnt<BLK_W, then 0.
  - After the cnt=KEY_W-1 cycle go to START.
- START (1 cycle): start_so=1, all data lanes 0. Next state WAIT.
- WAIT:
  - Stay while ready_si=0.
  - Only ready_si sampled high in WAIT counts; ready_si is ignored in all other states.
  - On ready_si=1: clear cnt, go to CAPTURE.
- CAPTURE (exactly TAG_W cycles, starting the cycle after ready_si was sampled high):
  - Each cycle shift tag_si into rsp_tag LSB (MSB first).
  - While cnt<BLK_W, also shift out_data_si into rsp_data.
  - After the cnt=TAG_W-1 cycle go to DONE.
- DONE:
  - rsp_valid=1; rsp_data and rsp_tag stable.
  - On rsp_ready=1: clear rsp_valid, go to IDLE.
  - cmd_valid is ignored until IDLE; the earliest new accept is the cycle after the handshake.
- decrypt_so holds its latched value from LOAD through DONE and returns to 0 in IDLE.
- cnt is 8 bits and never wraps within a phase; it is cleared on every phase entry.
- Minimum latency from command accept to rsp_valid: KEY_W + 1 + wait cycles + 1 + TAG_W cycles.

Optional Feature:
- Macro: ASCON_HOST_TIMEOUT_EN.
- Defined:
  - A TMO_W-bit watchdog clears on WAIT entry and increments each WAIT cycle.
  - If it reaches all-ones with ready_si still 0, go to DONE with rsp_timeout=1 and rsp_data=0, rsp_tag=0.
  - rsp_timeout clears on the rsp handshake.
- Undefined: no watchdog logic; rsp_timeout tied to 0; WAIT waits indefinitely.

Decomposition:
- Package ascon_host_pkg: state enum (IDLE, LOAD, START, WAIT, CAPTURE, DONE) and default width constants.
- One natural sub-module, ascon_host_shifter: a parameterized parallel-load/serial-out and serial-in/parallel-out shift register, instantiated per lane.

Test Plan:
- Reset with all-ones command lanes -> all serial outputs 0, cmd_ready=1, rsp_valid=0; rst asserted mid-LOAD -> IDLE on the next edge with no rsp_valid.
- key=128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210, nonce=~key, ad=64'hA5A5_0000_FFFF_1234, data=64'h1 -> lanes match MSB-first bits over 128 cycles, ad_so/data_so 0 from cycle 64, start_so high exactly one cycle at cycle 128.
- Core model raises ready_si 10 cycles after start, then drives tag 128'hDEAD_BEEF_..._CAFE and data 64'h5555_AAAA_0F0F_F0F0 MSB first -> rsp_valid after 128 capture cycles with exact values.
- Hold rsp_ready=0 for 20 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0; handshake -> IDLE, next command accepted one cycle later.
- ready_si pulsed during LOAD -> ignored; capture begins only after ready_si is high in WAIT. cmd_decrypt=1 -> decrypt_so=1 from LOAD through DONE.
- With ASCON_HOST_TIMEOUT_EN and ready_si held 0 -> rsp_valid with rsp_timeout=1 after 2^TMO_W-1 WAIT cycles; without the macro -> still in WAIT after 70000 cycles.

Source files
------------

// File: rtl/ascon_host_pkg.sv
// Shared types and default widths for the Ascon serial host.
package ascon_host_pkg;

    localparam int unsigned KEY_W_DEF = 128;
    localparam int unsigned BLK_W_DEF = 64;
    localparam int unsigned TAG_W_DEF = 128;
    localparam int unsigned TMO_W_DEF = 16;
    localparam int unsigned CNT_W     = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT,
        CAPTURE,
        DONE
    } state_t;

endpackage

// File: rtl/ascon_host_shifter.sv
// Parallel-load / serial-out and serial-in / parallel-out shift register, MSB first.
module ascon_host_shifter #(
    parameter int unsigned W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         shift,
    input  logic         sin,
    output logic [W-1:0] q,
    output logic         so
);

    // Load wins over shift; shifting moves toward the MSB so bits leave MSB first.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else if (load) begin
            q <= load_val;
        end else if (shift) begin
            q <= {q[W-2:0], sin};
        end
    end

    assign so = q[W-1];

endmodule

// File: rtl/ascon_serial_host.sv
// Host driver for the bit-serial Ascon core: serializes a command, pulses start,
// waits for ready and deserializes data and tag into a held response.
// Optional watchdog on the WAIT phase: define ASCON_HOST_TIMEOUT_EN.
module ascon_serial_host
    import ascon_host_pkg::*;
#(
    parameter int unsigned KEY_W = KEY_W_DEF,
    parameter int unsigned BLK_W = BLK_W_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned TMO_W = TMO_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_decrypt,
    input  logic [KEY_W-1:0] cmd_key,
    input  logic [KEY_W-1:0] cmd_nonce,
    input  logic [BLK_W-1:0] cmd_ad,
    input  logic [BLK_W-1:0] cmd_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [BLK_W-1:0] rsp_data,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_timeout,
    output logic             key_so,
    output logic             nonce_so,
    output logic             ad_so,
    output logic             data_so,
    output logic             start_so,
    output logic             decrypt_so,
    input  logic             out_data_si,
    input  logic             tag_si,
    input  logic             ready_si
);

    state_t           state, state_d;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             accept, load_shift, cap_tag, cap_data, hs;

    logic [KEY_W-1:0] key_par_unused, nonce_par_unused;
    logic [BLK_W-1:0] ad_par_unused, dat_par_unused;
    logic             tag_so_unused, cap_so_unused;

`ifdef ASCON_HOST_TIMEOUT_EN
    logic [TMO_W-1:0] tmo;
    logic             tmo_fire;
`else
    logic [TMO_W-1:0] tmo_unused;
    assign tmo_unused = '0;
`endif

    // State and phase counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
        end
    end

    // Next-state and per-phase strobes; lanes emptying to zero keeps them quiet outside LOAD.
    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        accept     = 1'b0;
        load_shift = 1'b0;
        cap_tag    = 1'b0;
        cap_data   = 1'b0;
        hs         = 1'b0;
`ifdef ASCON_HOST_TIMEOUT_EN
        tmo_fire   = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    accept  = 1'b1;
                    cnt_d   = '0;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                load_shift = 1'b1;
                cnt_d      = cnt + CNT_W'(1);
                if (cnt == CNT_W'(KEY_W - 1)) state_d = START;
            end
            START: state_d = WAIT;
            WAIT: begin
                if (ready_si) begin
                    cnt_d   = '0;
                    state_d = CAPTURE;
                end
`ifdef ASCON_HOST_TIMEOUT_EN
                else if (tmo == '1) begin
                    tmo_fire = 1'b1;
                    state_d  = DONE;
                end
`endif
            end
            CAPTURE: begin
                cap_tag  = 1'b1;
                cap_data = (cnt < CNT_W'(BLK_W));
                cnt_d    = cnt + CNT_W'(1);
                if (cnt == CNT_W'(TAG_W - 1)) state_d = DONE;
            end
            DONE: begin
                if (rsp_ready) begin
                    hs      = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registered handshake, start pulse and direction level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            start_so   <= 1'b0;
            decrypt_so <= 1'b0;
        end else begin
            cmd_ready  <= (state_d == IDLE);
            rsp_valid  <= (state_d == DONE);
            start_so   <= (state_d == START);
            if (accept) begin
                decrypt_so <= cmd_decrypt;
            end else if (state_d == IDLE) begin
                decrypt_so <= 1'b0;
            end
        end
    end

`ifdef ASCON_HOST_TIMEOUT_EN
    // Watchdog counts WAIT cycles; the timeout flag lives until the response handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tmo         <= '0;
            rsp_timeout <= 1'b0;
        end else begin
            tmo <= (state == WAIT) ? tmo + TMO_W'(1) : '0;
            if (tmo_fire) begin
                rsp_timeout <= 1'b1;
            end else if (hs) begin
                rsp_timeout <= 1'b0;
            end
        end
    end
`else
    assign rsp_timeout = 1'b0;
`endif

    ascon_host_shifter #(.W(KEY_W)) u_key (
        .clk(clk), .rst(rst), .load(accept), .load_val(cmd_key),
        .shift(load_shift), .sin(1'b0), .q(key_par_unused), .so(key_so)
    );

    ascon_host_shifter #(.W(KEY_W)) u_nonce (
        .clk(clk), .rst(rst), .load(accept), .load_val(cmd_nonce),
        .shift(load_shift), .sin(1'b0), .q(nonce_par_unused), .so(nonce_so)
    );

    ascon_host_shifter #(.W(BLK_W)) u_ad (
        .clk(clk), .rst(rst), .load(accept), .load_val(cmd_ad),
        .shift(load_shift), .sin(1'b0), .q(ad_par_unused), .so(ad_so)
    );

    ascon_host_shifter #(.W(BLK_W)) u_data (
        .clk(clk), .rst(rst), .load(accept), .load_val(cmd_data),
        .shift(load_shift), .sin(1'b0), .q(dat_par_unused), .so(data_so)
    );

    // Capture registers are zeroed on accept so a timed-out response reads as zero.
    ascon_host_shifter #(.W(TAG_W)) u_tag_cap (
        .clk(clk), .rst(rst), .load(accept), .load_val('0),
        .shift(cap_tag), .sin(tag_si), .q(rsp_tag), .so(tag_so_unused)
    );

    ascon_host_shifter #(.W(BLK_W)) u_data_cap (
        .clk(clk), .rst(rst), .load(accept), .load_val('0),
        .shift(cap_data), .sin(out_data_si), .q(rsp_data), .so(cap_so_unused)
    );

endmodule

// File: tb/tb_ascon_serial_host.sv
// Self-checking bench for ascon_serial_host with a cycle-offset transaction model.
module tb_ascon_serial_host;

    localparam int KW  = 128;
    localparam int BW  = 64;
    localparam int TW  = 128;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_decrypt;
    logic [KW-1:0] cmd_key, cmd_nonce;
    logic [BW-1:0] cmd_ad, cmd_data;
    logic          rsp_valid, rsp_ready, rsp_timeout;
    logic [BW-1:0] rsp_data;
    logic [TW-1:0] rsp_tag;
    logic          key_so, nonce_so, ad_so, data_so, start_so, decrypt_so;
    logic          out_data_si, tag_si, ready_si;

    always #5 clk = ~clk;

    ascon_serial_host dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_decrypt(cmd_decrypt),
        .cmd_key(cmd_key), .cmd_nonce(cmd_nonce), .cmd_ad(cmd_ad), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_tag(rsp_tag), .rsp_timeout(rsp_timeout),
        .key_so(key_so), .nonce_so(nonce_so), .ad_so(ad_so), .data_so(data_so),
        .start_so(start_so), .decrypt_so(decrypt_so),
        .out_data_si(out_data_si), .tag_si(tag_si), .ready_si(ready_si)
    );

    // Transaction table: command fields, core behaviour and response hold time.
    logic [KW-1:0] t_key [4];
    logic [KW-1:0] t_nonce [4];
    logic [BW-1:0] t_ad [4];
    logic [BW-1:0] t_data [4];
    logic          t_dec [4];
    logic [TW-1:0] t_ctag [4];
    logic [BW-1:0] t_cdata [4];
    int            t_rdy [4];
    int            t_g0 [4];
    int            t_g1 [4];
    int            t_hold [4];

    // Model: d = cycles since accept (-1 when idle), rdy_d = cycle ready was seen in WAIT.
    int            d = -1, rdy_d = -1, cap_end = 0, ti = 0;
    bit            tmo_hit = 1'b0, fresh = 1'b1, chk_en = 1'b0;
    logic [KW-1:0] m_key, m_nonce;
    logic [BW-1:0] m_ad, m_data, m_cdata;
    logic [TW-1:0] m_ctag;
    logic          m_dec;
    int            m_rdy, m_g0, m_g1;
    int            stall = 0, stall_ack = 0;
    int            checks = 0, errors = 0;

    function automatic bit m_valid();
        return (d >= 0) && (rdy_d >= 0 || tmo_hit) && (d >= cap_end);
    endfunction

    function automatic logic lane(input logic [127:0] v, input int idx, input int lim);
        if (idx >= 0 && idx < lim) return v[lim-1-idx];
        return 1'b0;
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b expected %0b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk128(input string nm, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Core model: drives ready and the MSB-first result lanes for the current cycle.
    task automatic drive_core();
        int j;
        ready_si    = 1'b0;
        tag_si      = 1'($urandom);
        out_data_si = 1'($urandom);
        if (d >= 0) begin
            ready_si = (d == m_g0) || (d == m_g1) || (m_rdy >= 0 && d >= m_rdy);
            if (rdy_d >= 0) begin
                j = d - rdy_d - 1;
                if (j >= 0 && j < TW) tag_si = m_ctag[TW-1-j];
                if (j >= 0 && j < BW) out_data_si = m_cdata[BW-1-j];
            end
        end
    endtask

    // One clock: update the model from the inputs seen at the edge, then drive the core.
    task automatic step();
        @(posedge clk);
        if (rst && d >= 0) begin
            if (d >= 129 && rdy_d < 0 && !tmo_hit) begin
                if (ready_si) begin
                    rdy_d   = d;
                    cap_end = d + 1 + TW;
                end
`ifdef ASCON_HOST_TIMEOUT_EN
                else if (d - 129 == (1 << TMO) - 1) begin
                    tmo_hit = 1'b1;
                    cap_end = d + 1;
                end
`endif
            end
            if (m_valid() && rsp_ready) begin
                d = -1; rdy_d = -1; tmo_hit = 1'b0;
            end else begin
                d++;
            end
        end else if (rst && cmd_valid) begin
            d = 0; rdy_d = -1; tmo_hit = 1'b0; fresh = 1'b0;
            m_key = cmd_key; m_nonce = cmd_nonce; m_ad = cmd_ad; m_data = cmd_data;
            m_dec = cmd_decrypt;
            m_ctag = t_ctag[ti]; m_cdata = t_cdata[ti];
            m_rdy = t_rdy[ti]; m_g0 = t_g0[ti]; m_g1 = t_g1[ti];
        end
        #1;
        drive_core();
    endtask

    task automatic drive_cmd(input int i);
        cmd_key = t_key[i]; cmd_nonce = t_nonce[i]; cmd_ad = t_ad[i];
        cmd_data = t_data[i]; cmd_decrypt = t_dec[i];
        cmd_valid = 1'b1;
    endtask

    task automatic start_txn(input int i);
        ti = i;
        drive_cmd(i);
        for (int k = 0; k < 5 && d < 0; k++) step();
        if (d < 0) stall++;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_txn(input int i, input bit next_pending);
        for (int k = 0; k < 2000 && !m_valid(); k++) step();
        if (!m_valid()) stall++;
        if (next_pending) drive_cmd(i + 1);
        repeat (t_hold[i]) step();
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic model_reset();
        d = -1; rdy_d = -1; tmo_hit = 1'b0; fresh = 1'b1;
    endtask

    // Compare process: every output against the model, plus literal pins.
    always @(negedge clk) begin : compare
        bit ev;
        if (chk_en) begin
            ev = m_valid();
            chk1("cmd_ready", cmd_ready, d < 0);
            chk1("key_so", key_so, lane(m_key, d, KW));
            chk1("nonce_so", nonce_so, lane(m_nonce, d, KW));
            chk1("ad_so", ad_so, lane({64'b0, m_ad}, d, BW));
            chk1("data_so", data_so, lane({64'b0, m_data}, d, BW));
            chk1("start_so", start_so, d == 128);
            chk1("decrypt_so", decrypt_so, (d >= 0) ? m_dec : 1'b0);
            chk1("rsp_valid", rsp_valid, ev);
            chk1("rsp_timeout", rsp_timeout, ev && tmo_hit);
            if (ev) begin
                chk128("rsp_tag", rsp_tag, tmo_hit ? 128'b0 : m_ctag);
                chk128("rsp_data", {64'b0, rsp_data}, tmo_hit ? 128'b0 : {64'b0, m_cdata});
            end
            if (fresh) begin
                chk128("rsp_tag_reset", rsp_tag, 128'b0);
                chk128("rsp_data_reset", {64'b0, rsp_data}, 128'b0);
            end
            chk1("bounded_wait", stall == stall_ack, 1'b1);
            stall_ack = stall;
            if (ti == 0 && d == 0) begin
                chk1("lit_nonce_msb", nonce_so, 1'b1);
                chk1("lit_ad_msb", ad_so, 1'b1);
                chk1("lit_key_msb", key_so, 1'b0);
            end
            if (ti == 0 && d == 7)   chk1("lit_key_bit120", key_so, 1'b1);
            if (ti == 0 && d == 63)  chk1("lit_data_lsb", data_so, 1'b1);
            if (ti == 0 && d == 64)  chk1("lit_ad_done", ad_so, 1'b0);
            if (ti == 0 && d == 128) chk1("lit_start", start_so, 1'b1);
            if (ti == 0 && d == 266) chk1("lit_valid_early", rsp_valid, 1'b0);
            if (ti == 0 && d == 267) begin
                chk1("lit_valid_latency", rsp_valid, 1'b1);
                chk128("lit_tag", rsp_tag, 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_CAFE);
                chk128("lit_data", {64'b0, rsp_data}, {64'b0, 64'h5555_AAAA_0F0F_F0F0});
            end
            if (ti == 1 && d == 0)   chk1("lit_next_accept", cmd_ready, 1'b0);
            if (ti == 1 && d == 200) chk1("lit_decrypt", decrypt_so, 1'b1);
            if (ti == 1 && d == 268) chk1("lit_glitch_ignored", rsp_valid, 1'b0);
            if (ti == 1 && d == 269) chk1("lit_glitch_valid", rsp_valid, 1'b1);
            if (ti == 3 && d == 70000) chk1("lit_still_wait", rsp_valid, 1'b0);
        end
    end

    initial begin
        t_key[0] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
        t_nonce[0] = ~t_key[0];
        t_ad[0] = 64'hA5A5_0000_FFFF_1234; t_data[0] = 64'h1; t_dec[0] = 1'b0;
        t_ctag[0] = 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_CAFE;
        t_cdata[0] = 64'h5555_AAAA_0F0F_F0F0;
        t_rdy[0] = 138; t_g0[0] = -1; t_g1[0] = -1; t_hold[0] = 20;

        t_key[1] = 128'hFFEE_DDCC_BBAA_9988_7766_5544_3322_1100;
        t_nonce[1] = 128'h8000_0000_0000_0000_0000_0000_0000_0001;
        t_ad[1] = 64'h8000_0000_0000_0001; t_data[1] = 64'hC3C3_3C3C_F00F_0FF0; t_dec[1] = 1'b1;
        t_ctag[1] = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E1F0;
        t_cdata[1] = 64'h8000_0000_0000_0001;
        t_rdy[1] = 140; t_g0[1] = 50; t_g1[1] = 128; t_hold[1] = 0;

        t_key[2] = 128'h1357_9BDF_0246_8ACE_1122_3344_5566_7788;
        t_nonce[2] = 128'hAAAA_5555_AAAA_5555_0000_FFFF_0000_FFFF;
        t_ad[2] = 64'hFFFF_FFFF_FFFF_FFFF; t_data[2] = 64'h0; t_dec[2] = 1'b0;
        t_ctag[2] = 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF;
        t_cdata[2] = 64'h0123_4567_89AB_CDEF;
        t_rdy[2] = 129; t_g0[2] = -1; t_g1[2] = -1; t_hold[2] = 3;

        t_key[3] = 128'hCAFE; t_nonce[3] = 128'hBEEF; t_ad[3] = 64'h1234; t_data[3] = 64'h5678;
        t_dec[3] = 1'b1; t_ctag[3] = 128'h1; t_cdata[3] = 64'h1;
        t_rdy[3] = -1; t_g0[3] = -1; t_g1[3] = -1; t_hold[3] = 0;

        // Reset with every input high.
        rst = 1'b0; cmd_valid = 1'b1; cmd_decrypt = 1'b1;
        cmd_key = '1; cmd_nonce = '1; cmd_ad = '1; cmd_data = '1;
        ready_si = 1'b1; tag_si = 1'b1; out_data_si = 1'b1; rsp_ready = 1'b1;
        m_key = '0; m_nonce = '0; m_ad = '0; m_data = '0; m_dec = 1'b0;
        m_ctag = '0; m_cdata = '0; m_rdy = -1; m_g0 = -1; m_g1 = -1;
        chk_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmd_valid = 1'b0; rsp_ready = 1'b0; ready_si = 1'b0; rst = 1'b1;
        step(); step();

        // Abort mid-LOAD with a reset.
        start_txn(0);
        for (int k = 0; k < 100 && d != 40; k++) step();
        if (d != 40) stall++;
        rst = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b1;
        step();

        // Full transactions; txn 0 is held in DONE while the next command waits.
        start_txn(0); finish_txn(0, 1'b1);
        start_txn(1); finish_txn(1, 1'b0);
        start_txn(2); finish_txn(2, 1'b0);

        // Core never answers.
        start_txn(3);
        rsp_ready = 1'b1;
        repeat (70005) step();
        rsp_ready = 1'b0;

        rst = 1'b0;
        model_reset();
        step(); step();
        rst = 1'b1;
        step();
        @(negedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
